// File: rtl/tri_pixel_iterator_pkg.sv
// -----------------------------------------------------------------------------
// tri_pixel_iterator_pkg
// Shared renderer definitions for the pixel iterator:
//   - screen size and coordinate width
//   - coordinate type (signed, COORD_W bits)
//   - traversal FSM state encoding
//   - signed min/max helpers used to build the bounding box
// -----------------------------------------------------------------------------
package tri_pixel_iterator_pkg;

  localparam int COORD_W  = 16;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic coord_t smin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t smax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tri_pixel_iterator_bbox_clamp.sv
// -----------------------------------------------------------------------------
// tri_pixel_iterator_bbox_clamp
// Combinational bounding box of three vertices, clamped to the screen.
// Ports:
//   i_x0..i_y2                 vertices (signed COORD_W)
//   o_min_x/o_max_x            clamped x range, 0..SCREEN_W-1
//   o_min_y/o_max_y            clamped y range, 0..SCREEN_H-1
//   o_empty                    box lies entirely off screen
// -----------------------------------------------------------------------------
module tri_pixel_iterator_bbox_clamp
  import tri_pixel_iterator_pkg::*;
(
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  input  logic signed [COORD_W-1:0] i_x2,
  input  logic signed [COORD_W-1:0] i_y2,
  output logic signed [COORD_W-1:0] o_min_x,
  output logic signed [COORD_W-1:0] o_max_x,
  output logic signed [COORD_W-1:0] o_min_y,
  output logic signed [COORD_W-1:0] o_max_y,
  output logic                      o_empty
);

  // Typed (signed) constants keep every comparison below signed.
  localparam coord_t ZERO  = '0;
  localparam coord_t X_LIM = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LIM = coord_t'(SCREEN_H - 1);

  coord_t w_raw_min_x;
  coord_t w_raw_max_x;
  coord_t w_raw_min_y;
  coord_t w_raw_max_y;

  assign w_raw_min_x = smin(smin(i_x0, i_x1), i_x2);
  assign w_raw_max_x = smax(smax(i_x0, i_x1), i_x2);
  assign w_raw_min_y = smin(smin(i_y0, i_y1), i_y2);
  assign w_raw_max_y = smax(smax(i_y0, i_y1), i_y2);

  assign o_min_x = (w_raw_min_x < ZERO)  ? ZERO  : w_raw_min_x;
  assign o_max_x = (w_raw_max_x > X_LIM) ? X_LIM : w_raw_max_x;
  assign o_min_y = (w_raw_min_y < ZERO)  ? ZERO  : w_raw_min_y;
  assign o_max_y = (w_raw_max_y > Y_LIM) ? Y_LIM : w_raw_max_y;

  // Emptiness is judged on the raw extremes, before clamping hides it.
  assign o_empty = (w_raw_max_x < ZERO) || (w_raw_min_x > X_LIM) ||
                   (w_raw_max_y < ZERO) || (w_raw_min_y > Y_LIM);

endmodule

// File: rtl/tri_pixel_iterator.sv
// -----------------------------------------------------------------------------
// tri_pixel_iterator
// Latches a triangle on a start handshake, builds its screen-clamped bounding
// box and emits every pixel in that box in raster order, one per unstalled
// cycle. Backpressure inserts bubbles (o_valid low); no pixel is ever held.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start                    start request, taken only while o_busy is low
//   i_x0..i_y2                 triangle vertices, sampled on the accept edge
//   i_stall                    downstream hold, no pixel emitted on that edge
//   o_busy                     accept edge until o_done
//   o_x0..o_y2                 latched vertices for the edge engine
//   o_p_x, o_p_y, o_valid      current pixel and its qualifier
//   o_done                     one-cycle completion pulse
// -----------------------------------------------------------------------------
module tri_pixel_iterator
  import tri_pixel_iterator_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic signed [COORD_W-1:0] i_x0,
  input  logic signed [COORD_W-1:0] i_y0,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  input  logic signed [COORD_W-1:0] i_x2,
  input  logic signed [COORD_W-1:0] i_y2,
  input  logic                      i_stall,
  output logic                      o_busy,
  output logic signed [COORD_W-1:0] o_x0,
  output logic signed [COORD_W-1:0] o_y0,
  output logic signed [COORD_W-1:0] o_x1,
  output logic signed [COORD_W-1:0] o_y1,
  output logic signed [COORD_W-1:0] o_x2,
  output logic signed [COORD_W-1:0] o_y2,
  output logic signed [COORD_W-1:0] o_p_x,
  output logic signed [COORD_W-1:0] o_p_y,
  output logic                      o_valid,
  output logic                      o_done
);

  state_t r_state;
  state_t w_next_state;

  coord_t r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  coord_t r_min_x, r_max_x, r_max_y;
  coord_t r_cur_x, r_cur_y;
  coord_t r_p_x, r_p_y;
  logic   r_busy, r_valid, r_done;

  coord_t w_min_x, w_max_x, w_min_y, w_max_y;
  logic   w_empty;
  logic   w_accept;
  logic   w_emit;
  logic   w_row_end;

  tri_pixel_iterator_bbox_clamp u_bbox_clamp (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_x1    (r_x1),
    .i_y1    (r_y1),
    .i_x2    (r_x2),
    .i_y2    (r_y2),
    .o_min_x (w_min_x),
    .o_max_x (w_max_x),
    .o_min_y (w_min_y),
    .o_max_y (w_max_y),
    .o_empty (w_empty)
  );

  assign w_row_end = (r_cur_x == r_max_x);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        w_next_state = w_empty ? DONE : SCAN;
      end
      SCAN: begin
        if (!i_stall) begin
          w_emit = 1'b1;
          // The pixel leaving now is (max_x,max_y): traversal is complete.
          if (w_row_end && (r_cur_y == r_max_y)) begin
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_min_x <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_p_x   <= '0;
      r_p_y   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x0   <= i_x0;
        r_y0   <= i_y0;
        r_x1   <= i_x1;
        r_y1   <= i_y1;
        r_x2   <= i_x2;
        r_y2   <= i_y2;
        r_busy <= 1'b1;
      end

      // Box registered once; min_y is only needed to seed the row counter.
      if (r_state == SETUP) begin
        r_min_x <= w_min_x;
        r_max_x <= w_max_x;
        r_max_y <= w_max_y;
        r_cur_x <= w_min_x;
        r_cur_y <= w_min_y;
      end

      // Stalled edges leave a bubble; pixel registers keep their last value.
      r_valid <= w_emit;
      if (w_emit) begin
        r_p_x <= r_cur_x;
        r_p_y <= r_cur_y;
        if (w_row_end) begin
          r_cur_x <= r_min_x;
          r_cur_y <= r_cur_y + coord_t'(1);
        end else begin
          r_cur_x <= r_cur_x + coord_t'(1);
        end
      end

      // Done pulse and busy release land together on the edge leaving DONE.
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_p_x   = r_p_x;
  assign o_p_y   = r_p_y;
  assign o_x0    = r_x0;
  assign o_y0    = r_y0;
  assign o_x1    = r_x1;
  assign o_y1    = r_y1;
  assign o_x2    = r_x2;
  assign o_y2    = r_y2;

endmodule
